// File: rtl/ccff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_pkg
//  Description : Shared definitions for the configuration-chain loader:
//                sequencer state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package ccff_pkg;

    // Sequencer states. Width is fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISO_PRE  = 3'd1,
        SHIFT    = 3'd2,
        ISO_POST = 3'd3,
        FAIL     = 3'd4
    } ccff_state_e;

    // Default geometry of the attached I/O tile column.
    localparam int c_chain_len_def = 32;
    localparam int c_word_w_def    = 8;
    localparam int c_iso_cyc_def   = 2;
    localparam int c_stall_max_def = 255;

endpackage
`default_nettype wire

// File: rtl/ccff_rb_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_rb_packer
//  Description : Serial-to-word packer for configuration readback. Bits
//                arriving on tail_bit with strobe are placed LSB first; a
//                word is emitted after WORD_W bits, or early on flush with
//                the unfilled upper bits left at zero.
//  Ports       : prog_clk, prog_reset_n (async, active-low)
//                clear    - drop any partially collected word
//                tail_bit - serial bit captured from the chain end
//                strobe   - tail_bit is valid this cycle
//                flush    - this strobe carries the final chain bit
//                rb_data  - packed readback word (registered)
//                rb_valid - one-cycle strobe for rb_data (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_rb_packer
    import ccff_pkg::*;
#(
    parameter int WORD_W = c_word_w_def
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              clear,
    input  logic              tail_bit,
    input  logic              strobe,
    input  logic              flush,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int c_cnt_w = $clog2(WORD_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_pos = c_cnt_w'(WORD_W - 1);

    logic [WORD_W-1:0]  r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WORD_W-1:0]  r_rb_data;
    logic               r_rb_valid;

    logic [WORD_W-1:0]  w_acc_nxt;
    logic               w_full;

    // Accumulator with the incoming bit merged in at its position; this is
    // what gets published when the word completes in the same cycle.
    assign w_acc_nxt = r_acc | (WORD_W'(tail_bit) << r_cnt);
    assign w_full    = (r_cnt == c_last_pos);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (strobe) begin
                if (w_full || flush) begin
                    // Accumulator restarts at zero, which gives the
                    // zero padding of a flushed partial word for free.
                    r_rb_data  <= w_acc_nxt;
                    r_rb_valid <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_chain_loader
//  Description : Configuration-chain sequencer for an I/O tile column.
//                Accepts bitstream words on a valid/ready stream, shifts them
//                LSB first into ccff_head one bit per enabled cycle, isolates
//                the pads (isol_n low) around the reload, and returns the old
//                chain contents seen on ccff_tail as readback words.
//  Ports       : prog_clk, prog_reset_n (async, active-low)
//                start                       - begin a load (IDLE/FAIL only)
//                cfg_data/cfg_valid/cfg_ready - bitstream word stream
//                ccff_head, ccff_tail, chain_en - chain serial interface
//                isol_n                      - pad isolation, active-low
//                rb_data/rb_valid            - readback words
//                busy, done, err             - status
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = c_chain_len_def,
    parameter int WORD_W    = c_word_w_def,
    parameter int ISO_CYC   = c_iso_cyc_def,
    parameter int STALL_MAX = c_stall_max_def
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_en,
    output logic              isol_n,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_bits_w  = $clog2(CHAIN_LEN + 1);
    localparam int c_stall_w = $clog2(STALL_MAX + 1);
    localparam int c_iso_w   = $clog2(ISO_CYC + 1);
    localparam int c_cnt_w   = $clog2(WORD_W + 1);

    localparam logic [c_bits_w-1:0]  c_bits_last  = c_bits_w'(CHAIN_LEN - 1);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_MAX - 1);
    localparam logic [c_iso_w-1:0]   c_iso_last   = c_iso_w'(ISO_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_word_bits  = c_cnt_w'(WORD_W);

    ccff_state_e          r_state;
    logic [c_iso_w-1:0]   r_iso_cnt;
    logic [c_bits_w-1:0]  r_bits_done;
    logic [c_stall_w-1:0] r_stall_cnt;
    logic [WORD_W-1:0]    r_buf;
    logic [c_cnt_w-1:0]   r_buf_cnt;
    logic                 r_chain_en;
    logic                 r_isol_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_shift;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_load_start;
    logic [WORD_W-1:0]    w_buf_nxt;
    logic [c_cnt_w-1:0]   w_buf_cnt_nxt;

    // A shift cycle is any SHIFT cycle with bits left in the word buffer.
    assign w_shift = (r_state == SHIFT) && (r_buf_cnt != '0);
    assign w_last  = w_shift && (r_bits_done == c_bits_last);

    // Taking a new word while the final buffered bit leaves keeps the chain
    // shifting every cycle; no word is requested once the chain is full.
    assign w_ready = (r_state == SHIFT) &&
                     ((r_buf_cnt == '0) ||
                      ((r_buf_cnt == c_cnt_w'(1)) && !w_last));
    assign w_accept     = cfg_valid && w_ready;
    assign w_load_start = start && ((r_state == IDLE) || (r_state == FAIL));

    always_comb begin
        w_buf_nxt     = r_buf;
        w_buf_cnt_nxt = r_buf_cnt;
        if (w_accept) begin
            w_buf_nxt     = cfg_data;
            w_buf_cnt_nxt = c_word_bits;
        end else if (w_shift) begin
            w_buf_nxt     = r_buf >> 1;
            w_buf_cnt_nxt = r_buf_cnt - c_cnt_w'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= IDLE;
            r_iso_cnt   <= '0;
            r_bits_done <= '0;
            r_stall_cnt <= '0;
            r_buf       <= '0;
            r_buf_cnt   <= '0;
            r_chain_en  <= 1'b0;
            r_isol_n    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FAIL: begin
                    if (start) begin
                        r_state     <= ISO_PRE;
                        r_iso_cnt   <= '0;
                        r_bits_done <= '0;
                        r_stall_cnt <= '0;
                        r_buf       <= '0;
                        r_buf_cnt   <= '0;
                        r_err       <= 1'b0;
                        r_isol_n    <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                ISO_PRE: begin
                    if (r_iso_cnt == c_iso_last) begin
                        r_iso_cnt <= '0;
                        r_state   <= SHIFT;
                    end else begin
                        r_iso_cnt <= r_iso_cnt + c_iso_w'(1);
                    end
                end

                SHIFT: begin
                    if (w_shift) begin
                        r_stall_cnt <= '0;
                        r_bits_done <= r_bits_done + c_bits_w'(1);
                        if (w_last) begin
                            // Any unshifted remainder of the word is dropped.
                            r_buf      <= '0;
                            r_buf_cnt  <= '0;
                            r_chain_en <= 1'b0;
                            r_state    <= ISO_POST;
                        end else begin
                            r_buf      <= w_buf_nxt;
                            r_buf_cnt  <= w_buf_cnt_nxt;
                            r_chain_en <= (w_buf_cnt_nxt != '0);
                        end
                    end else begin
                        r_buf       <= w_buf_nxt;
                        r_buf_cnt   <= w_buf_cnt_nxt;
                        r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
                        // A word arriving on the limit cycle still rescues
                        // the load, since it shifts on the very next cycle.
                        if ((r_stall_cnt == c_stall_last) && !w_accept) begin
                            r_state    <= FAIL;
                            r_err      <= 1'b1;
                            r_chain_en <= 1'b0;
                        end else begin
                            r_chain_en <= w_accept;
                        end
                    end
                end

                ISO_POST: begin
                    if (r_iso_cnt == c_iso_last) begin
                        r_iso_cnt <= '0;
                        r_state   <= IDLE;
                        r_isol_n  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_iso_cnt <= r_iso_cnt + c_iso_w'(1);
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_chain_en <= 1'b0;
                    r_isol_n   <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_rb_packer (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clear        (w_load_start),
        .tail_bit     (ccff_tail),
        .strobe       (w_shift),
        .flush        (w_last),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
    );

    assign cfg_ready = w_ready;
    assign ccff_head = w_shift & r_buf[0];
    assign chain_en  = r_chain_en;
    assign isol_n    = r_isol_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
